// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_ctrl
//  Description : VGA raster timing generator. Steps a horizontal and a
//                vertical phase FSM on each pixel-enable cycle and produces
//                registered sync, blanking and start-of-line/frame strobes
//                aligned with the pixel counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_ctrl #(
    parameter int H_ACTIVE      = 640,
    parameter int H_FRONT_PORCH = 16,
    parameter int H_SYNC_WIDTH  = 96,
    parameter int H_BACK_PORCH  = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_SYNC_WIDTH  = 2,
    parameter int V_BACK_PORCH  = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       display_on,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    // Last position of each phase; a phase ends when its counter steps past it.
    localparam logic [9:0] C_H_ACT_LAST  = 10'(H_ACTIVE - 1);
    localparam logic [9:0] C_H_FP_LAST   = 10'(H_ACTIVE + H_FRONT_PORCH - 1);
    localparam logic [9:0] C_H_SYNC_LAST = 10'(H_ACTIVE + H_FRONT_PORCH + H_SYNC_WIDTH - 1);
    localparam logic [9:0] C_H_LAST      = 10'(H_ACTIVE + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH - 1);
    localparam logic [9:0] C_V_ACT_LAST  = 10'(V_ACTIVE - 1);
    localparam logic [9:0] C_V_FP_LAST   = 10'(V_ACTIVE + V_FRONT_PORCH - 1);
    localparam logic [9:0] C_V_SYNC_LAST = 10'(V_ACTIVE + V_FRONT_PORCH + V_SYNC_WIDTH - 1);
    localparam logic [9:0] C_V_LAST      = 10'(V_ACTIVE + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH - 1);

    typedef enum logic [1:0] {
        H_ACT  = 2'd0,
        H_FP   = 2'd1,
        H_SYNC = 2'd2,
        H_BP   = 2'd3
    } h_state_e;

    typedef enum logic [1:0] {
        V_ACT  = 2'd0,
        V_FP   = 2'd1,
        V_SYNC = 2'd2,
        V_BP   = 2'd3
    } v_state_e;

    h_state_e   hstate_q, hstate_d;
    v_state_e   vstate_q, vstate_d;
    logic [9:0] hpos_q, hpos_d;
    logic [9:0] vpos_q, vpos_d;
    logic [7:0] frame_q, frame_d;
    // Cleared by reset; the first enabled cycle afterwards only presents
    // position (0,0) with its start strobes, counting begins one step later.
    logic       armed_q;
    logic       hsync_n_q, hsync_n_d;
    logic       vsync_n_q, vsync_n_d;
    logic       display_on_q, display_on_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;

    // Next counter values and FSM phases, plus the output values they imply.
    always_comb begin
        hpos_d   = hpos_q;
        vpos_d   = vpos_q;
        frame_d  = frame_q;
        hstate_d = hstate_q;
        vstate_d = vstate_q;

        if (ce && armed_q) begin
            hpos_d = (hpos_q == C_H_LAST) ? 10'd0 : hpos_q + 10'd1;

            unique case (hstate_q)
                H_ACT:  if (hpos_q == C_H_ACT_LAST)  hstate_d = H_FP;
                H_FP:   if (hpos_q == C_H_FP_LAST)   hstate_d = H_SYNC;
                H_SYNC: if (hpos_q == C_H_SYNC_LAST) hstate_d = H_BP;
                H_BP:   if (hpos_q == C_H_LAST)      hstate_d = H_ACT;
            endcase

            if (hpos_q == C_H_LAST) begin
                vpos_d = (vpos_q == C_V_LAST) ? 10'd0 : vpos_q + 10'd1;

                unique case (vstate_q)
                    V_ACT:  if (vpos_q == C_V_ACT_LAST)  vstate_d = V_FP;
                    V_FP:   if (vpos_q == C_V_FP_LAST)   vstate_d = V_SYNC;
                    V_SYNC: if (vpos_q == C_V_SYNC_LAST) vstate_d = V_BP;
                    V_BP:   if (vpos_q == C_V_LAST)      vstate_d = V_ACT;
                endcase

                if (vpos_q == C_V_LAST) begin
                    frame_d = frame_q + 8'd1;
                end
            end
        end

        hsync_n_d     = (hstate_d != H_SYNC);
        vsync_n_d     = (vstate_d != V_SYNC);
        display_on_d  = (hstate_d == H_ACT) && (vstate_d == V_ACT);
        line_start_d  = ce && (hpos_d == 10'd0);
        frame_start_d = ce && (hpos_d == 10'd0) && (vpos_d == 10'd0);
    end

    // State registers; outputs refresh only on enabled cycles so they hold with ce=0.
    always_ff @(posedge clk) begin
        if (reset) begin
            hpos_q        <= 10'd0;
            vpos_q        <= 10'd0;
            frame_q       <= 8'd0;
            hstate_q      <= H_ACT;
            vstate_q      <= V_ACT;
            armed_q       <= 1'b0;
            hsync_n_q     <= 1'b1;
            vsync_n_q     <= 1'b1;
            display_on_q  <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            frame_q       <= frame_d;
            hstate_q      <= hstate_d;
            vstate_q      <= vstate_d;
            armed_q       <= armed_q | ce;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            if (ce) begin
                hsync_n_q    <= hsync_n_d;
                vsync_n_q    <= vsync_n_d;
                display_on_q <= display_on_d;
            end
        end
    end

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign frame_cnt   = frame_q;
    assign hsync_n     = hsync_n_q;
    assign vsync_n     = vsync_n_q;
    assign display_on  = display_on_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_ctrl
//  Description : Scoreboard bench for vga_timing_ctrl. One full-size 640x480
//                instance and one miniature-raster instance share stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_ctrl;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic [7:0] f;
        logic       hs;
        logic       vs;
        logic       de;
        logic       ls;
        logic       fs;
    } out_t;

    typedef struct packed {
        logic armed;
        out_t o;
    } mdl_t;

    typedef struct packed {
        out_t big;
        out_t sml;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ce = 1'b0;

    logic [9:0] b_hpos, b_vpos, s_hpos, s_vpos;
    logic [7:0] b_frame, s_frame;
    logic       b_hs, b_vs, b_de, b_ls, b_fs;
    logic       s_hs, s_vs, s_de, s_ls, s_fs;
    out_t       act_b, act_s;

    int   n_vec = 0;
    int   n_bad = 0;
    int   mode  = 0;   // 0: unmeasured, 1: ce held high, 2: ce toggling 1,0
    exp_t exp_q[$];
    mdl_t mb, ms;

    always #5 clk = ~clk;

    vga_timing_ctrl u_big (
        .clk(clk), .reset(reset), .ce(ce),
        .hpos(b_hpos), .vpos(b_vpos), .hsync_n(b_hs), .vsync_n(b_vs),
        .display_on(b_de), .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_frame)
    );

    // Miniature raster: H 8/2/3/2 (15 total), V 4/2/2/3 (11 total), 165 cycles per frame.
    vga_timing_ctrl #(
        .H_ACTIVE(8), .H_FRONT_PORCH(2), .H_SYNC_WIDTH(3), .H_BACK_PORCH(2),
        .V_ACTIVE(4), .V_FRONT_PORCH(2), .V_SYNC_WIDTH(2), .V_BACK_PORCH(3)
    ) u_sml (
        .clk(clk), .reset(reset), .ce(ce),
        .hpos(s_hpos), .vpos(s_vpos), .hsync_n(s_hs), .vsync_n(s_vs),
        .display_on(s_de), .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_frame)
    );

    assign act_b = {b_hpos, b_vpos, b_frame, b_hs, b_vs, b_de, b_ls, b_fs};
    assign act_s = {s_hpos, s_vpos, s_frame, s_hs, s_vs, s_de, s_ls, s_fs};

    // Reference raster model: position arithmetic, not a phase machine.
    function automatic mdl_t mdl_step(input mdl_t m, input bit r, input bit c,
                                      input int ha, input int hfp, input int hsw, input int hbp,
                                      input int va, input int vfp, input int vsw, input int vbp);
        int ht = ha + hfp + hsw + hbp;
        int vt = va + vfp + vsw + vbp;
        int h  = int'(m.o.h);
        int v  = int'(m.o.v);
        int f  = int'(m.o.f);
        if (r) begin
            m.armed = 1'b0;
            h = 0; v = 0; f = 0;
            m.o.hs = 1'b1; m.o.vs = 1'b1; m.o.de = 1'b0; m.o.ls = 1'b0; m.o.fs = 1'b0;
        end else if (c) begin
            if (!m.armed) begin
                m.armed = 1'b1;
            end else if (h == ht - 1) begin
                h = 0;
                if (v == vt - 1) begin
                    v = 0;
                    f = (f + 1) % 256;
                end else begin
                    v = v + 1;
                end
            end else begin
                h = h + 1;
            end
            m.o.hs = !(h >= ha + hfp && h < ha + hfp + hsw);
            m.o.vs = !(v >= va + vfp && v < va + vfp + vsw);
            m.o.de = (h < ha) && (v < va);
            m.o.ls = (h == 0);
            m.o.fs = (h == 0) && (v == 0);
        end else begin
            m.o.ls = 1'b0;
            m.o.fs = 1'b0;
        end
        m.o.h = 10'(h);
        m.o.v = 10'(v);
        m.o.f = 8'(f);
        return m;
    endfunction

    task automatic dchk(input string nm, input int a, input int x);
        n_vec++;
        if (a != x) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, a, x, $time);
        end
    endtask

    task automatic ochk(input string nm, input out_t a, input out_t x);
        n_vec++;
        if (a !== x) begin
            n_bad++;
            $display("FAIL %s t=%0t got(h=%0d v=%0d f=%0d hs=%b vs=%b de=%b ls=%b fs=%b) want(h=%0d v=%0d f=%0d hs=%b vs=%b de=%b ls=%b fs=%b)",
                     nm, $time, a.h, a.v, a.f, a.hs, a.vs, a.de, a.ls, a.fs,
                     x.h, x.v, x.f, x.hs, x.vs, x.de, x.ls, x.fs);
        end
    endtask

    // Drive one cycle of stimulus and queue the response it must produce.
    task automatic step(input bit r, input bit c, input int m);
        exp_t e;
        @(negedge clk);
        reset = r;
        ce    = c;
        mode  = m;
        mb = mdl_step(mb, r, c, 640, 16, 96, 48, 480, 10, 2, 33);
        ms = mdl_step(ms, r, c, 8, 2, 3, 2, 4, 2, 2, 3);
        e.big = mb.o;
        e.sml = ms.o;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: one expected record per clock edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ochk("big_cycle", act_b, e.big);
            ochk("sml_cycle", act_s, e.sml);
        end
    end

    // Interval measurements against hand-derived raster figures.
    int   last_mode = 0;
    int   rel_cyc = 0;
    int   b_len = 0, b_hlow = 0, b_dcnt = 0;
    int   s_len = 0, s_vlow = 0;
    bit   b_valid = 0, b_vis = 0, s_valid = 0, wrap_seen = 0;
    logic b_hs_prev = 1'b1, s_vs_prev = 1'b1;
    logic [7:0] s_fprev = 8'd0;

    always @(posedge clk) begin
        #1;
        if (mode != last_mode) begin
            b_valid   = 0;
            s_valid   = 0;
            last_mode = mode;
        end
        rel_cyc = (mode == 1) ? rel_cyc + 1 : 0;
        if (rel_cyc == 1) begin
            dchk("release_frame_start", int'(b_fs), 1);
            dchk("release_line_start", int'(b_ls), 1);
            dchk("release_hpos", int'(b_hpos), 0);
            dchk("release_display_on", int'(b_de), 1);
        end else if (rel_cyc == 2) begin
            dchk("second_hpos", int'(b_hpos), 1);
            dchk("second_line_start", int'(b_ls), 0);
            dchk("second_frame_start", int'(b_fs), 0);
        end
        if (mode != 0) begin
            if (b_ls) begin
                if (b_valid) begin
                    dchk("line_period", b_len, 800 * mode);
                    dchk("hsync_low_cycles", b_hlow, 96 * mode);
                    if (b_vis) dchk("display_on_cycles", b_dcnt, 640 * mode);
                end
                b_valid = 1;
                b_len = 0; b_hlow = 0; b_dcnt = 0;
                b_vis = (b_vpos < 10'd480);
            end
            b_len++;
            if (!b_hs) b_hlow++;
            if (b_de) b_dcnt++;
            if (b_hs_prev && !b_hs) dchk("hsync_fall_hpos", int'(b_hpos), 656);

            if (s_fs) begin
                if (s_valid) begin
                    dchk("frame_period", s_len, 165 * mode);
                    dchk("vsync_low_cycles", s_vlow, 30 * mode);
                end
                s_valid = 1;
                s_len = 0; s_vlow = 0;
            end
            s_len++;
            if (!s_vs) s_vlow++;
            if (s_vs_prev && !s_vs) begin
                dchk("vsync_fall_vpos", int'(s_vpos), 6);
                dchk("vsync_fall_hpos", int'(s_hpos), 0);
            end
            dchk("display_in_vblank", int'(s_de && (s_vpos >= 10'd4)), 0);
        end
        if (s_fs && s_fprev == 8'd255) begin
            wrap_seen = 1;
            dchk("wrap_frame_cnt", int'(s_frame), 0);
            dchk("wrap_hpos", int'(s_hpos), 0);
            dchk("wrap_vpos", int'(s_vpos), 0);
        end
        b_hs_prev = b_hs;
        s_vs_prev = s_vs;
        s_fprev   = s_frame;
    end

    initial begin
        bit found;
        mb = '0;
        ms = '0;

        // Reset holds regardless of ce.
        step(1, 1, 0);
        step(1, 0, 0);
        step(1, 1, 0);

        // Release with ce held: two full 800-cycle lines, ~10 mini frames.
        for (int i = 0; i < 1700; i++) step(0, 1, 1);

        // ce toggling 1,0: periods double, outputs hold on ce=0 cycles.
        for (int i = 0; i < 5000; i++) step(0, (i % 2) == 0, 2);

        // Mid-line reset on the full-size raster while hsync is active.
        found = 0;
        for (int i = 0; i < 900 && !found; i++) begin
            step(0, 1, 0);
            if (mb.o.h == 10'd700) found = 1;
        end
        dchk("reach_hpos_700", int'(found), 1);
        step(1, 1, 0);
        step(0, 1, 0);

        // Reset on the mini raster while both syncs are low.
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            step(0, 1, 0);
            if (!ms.o.hs && !ms.o.vs) found = 1;
        end
        dchk("reach_both_sync_low", int'(found), 1);
        step(1, 0, 0);

        // Release again and run past 256 mini frames to see frame_cnt wrap.
        for (int i = 0; i < 256 * 165 + 200; i++) step(0, 1, 1);
        step(0, 0, 0);
        step(0, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        dchk("frame_wrap_seen", int'(wrap_seen), 1);
        dchk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
